perf_ctrl: RTL and testbench

PERF_CTRL -- requirements
Module: perf_ctrl

---
 rtl/perf_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_perf_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_ctrl.sv
// perf_ctrl: Wishbone-controlled measurement window sequencer for external
// performance counters. Software programs a window length, starts a run, and
// the block pulses cnt_clr, holds cnt_en for the window, then pulses snap so
// the counters capture their values. Optional continuous mode re-arms after
// every window; DONE is sticky and can raise a level interrupt.
module perf_ctrl #(
    parameter logic [31:0] BASE_ADR   = 32'h99000100,
    parameter logic [31:0] RST_WINDOW = 32'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_o,
    output logic [31:0] wb_dat_i,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_rty,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic        snap,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        cont_q;
    logic        irq_en_q;
    logic        done_q;
    logic [31:0] window_q;
    logic [31:0] win_q;
    logic [31:0] elapsed_q;
    logic [31:0] runs_q;

    // Address decode: the block spans 32 bytes so offsets past RUNS still ack
    // and read as zero.
    logic [31:0] off;
    logic [2:0]  reg_idx;
    logic        in_block;
    logic        sel;
    logic        acc;
    logic        wr_acc;
    logic        rd_acc;
    logic        ctrl_wr;
    logic        status_wr;
    logic        window_wr;
    logic        start_req;
    logic        stop_req;
    logic        expire;
    logic        run_end;
    logic [31:0] rdata;

    assign off       = wb_adr - BASE_ADR;
    assign in_block  = (off < 32'h20);
    assign reg_idx   = off[4:2];
    assign sel       = wb_cyc & wb_stb & in_block;
    assign acc       = sel & ~ack_q;
    assign wr_acc    = acc & wb_we;
    assign rd_acc    = acc & ~wb_we;
    assign ctrl_wr   = wr_acc & (reg_idx == 3'd0);
    assign status_wr = wr_acc & (reg_idx == 3'd1);
    assign window_wr = wr_acc & (reg_idx == 3'd2);

    // STOP has priority over START when both bits are written together.
    assign start_req = ctrl_wr & wb_dat_o[0] & ~wb_dat_o[1];
    assign stop_req  = ctrl_wr & wb_dat_o[1];

    // A zero window never expires; only STOP ends such a run.
    assign expire  = (state == S_RUN) && (win_q != 32'd0) && (elapsed_q == win_q - 32'd1);
    // Expiry and STOP in the same cycle end the window once.
    assign run_end = (state == S_RUN) && (stop_req || expire);

    // Counter controls decode from the registered state; gating with rst
    // keeps a reset mid-window from producing a snap pulse.
    assign cnt_clr  = ~rst & (state == S_CLEAR);
    assign cnt_en   = ~rst & (state == S_RUN);
    assign snap     = ~rst & run_end;
    assign irq      = done_q & irq_en_q;
    assign wb_ack   = ack_q;
    assign wb_dat_i = dat_q;
    assign wb_err   = 1'b0;
    assign wb_rty   = 1'b0;

    // Read multiplexer for the register map.
    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            3'd0:    rdata = {28'd0, irq_en_q, cont_q, 2'b00};
            3'd1:    rdata = {29'd0, done_q, state};
            3'd2:    rdata = window_q;
            3'd3:    rdata = elapsed_q;
            3'd4:    rdata = runs_q;
            default: rdata = 32'd0;
        endcase
    end

    // Bus handshake: one ack per access, read data captured alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= acc;
            dat_q <= rd_acc ? rdata : 32'd0;
        end
    end

    // Software-visible configuration and the sticky DONE flag (set beats W1C).
    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
            window_q <= RST_WINDOW;
            done_q   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                cont_q   <= wb_dat_o[2];
                irq_en_q <= wb_dat_o[3];
            end
            if (window_wr) begin
                window_q <= wb_dat_o;
            end
            if (run_end) begin
                done_q <= 1'b1;
            end else if (status_wr && wb_dat_o[2]) begin
                done_q <= 1'b0;
            end
        end
    end

    // Window sequencer: IDLE/DONE -> CLEAR -> RUN -> DONE, or back to CLEAR
    // in continuous mode; the window length is latched on every CLEAR entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            win_q     <= 32'd0;
            elapsed_q <= 32'd0;
            runs_q    <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        state     <= S_CLEAR;
                        win_q     <= window_q;
                        elapsed_q <= 32'd0;
                    end
                end
                S_CLEAR: begin
                    state <= stop_req ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (run_end) begin
                        runs_q <= runs_q + 32'd1;
                        if (!stop_req && cont_q) begin
                            state     <= S_CLEAR;
                            win_q     <= window_q;
                            elapsed_q <= 32'd0;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        elapsed_q <= elapsed_q + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_ctrl.sv
// Testbench for perf_ctrl: a timestamp-based reference model predicts the
// per-cycle control outputs and every bus response; a monitor pops and
// compares those predictions while directed and random stimulus drives the bus.
module tb_perf_ctrl;

    localparam logic [31:0] BASE = 32'h99000100;
    localparam logic [31:0] RSTW = 32'd1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack, wb_err, wb_rty;
    logic        cnt_clr, cnt_en, snap, irq;

    always #5 clk = ~clk;

    perf_ctrl #(.BASE_ADR(BASE), .RST_WINDOW(RSTW)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .snap(snap), .irq(irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state. Modes: 0 idle, 1 clear, 2 run, 3 done.
    // While running, elapsed is derived from the cycle the run began.
    int          mcyc = 0;
    int          m_st;
    int          m_t0;
    logic        m_valid = 1'b0;
    logic        m_cont, m_irqen, m_done, m_ack;
    logic [31:0] m_window, m_win, m_elapsed, m_runs;

    logic [4:0]  exp_q[$];
    logic [31:0] rd_q[$];

    int en_total = 0, clr_total = 0, snap_total = 0;
    int snap_en[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_t0 = 0;
        m_cont = 1'b0; m_irqen = 1'b0; m_done = 1'b0; m_ack = 1'b0;
        m_window = RSTW; m_win = 32'd0; m_elapsed = 32'd0; m_runs = 32'd0;
    endtask

    task automatic model_proc();
        logic [31:0] off, d, rv, el;
        logic        acc, wr, rd, start, stop, expire, fin;
        int          idx, cur;
        forever begin
            @(negedge clk);
            cur = mcyc;
            mcyc++;
            if (!m_valid) begin
                if (rst) begin
                    model_reset();
                    m_valid = 1'b1;
                end
            end else if (rst) begin
                exp_q.push_back({3'b000, m_done & m_irqen, m_ack});
                model_reset();
            end else begin
                off   = wb_adr - BASE;
                acc   = wb_cyc && wb_stb && (off < 32) && !m_ack;
                idx   = int'(off >> 2);
                wr    = acc && wb_we;
                rd    = acc && !wb_we;
                d     = wb_dat_o;
                start = wr && idx == 0 && d[0] && !d[1];
                stop  = wr && idx == 0 && d[1];
                el    = (m_st == 2) ? 32'(cur - m_t0) : m_elapsed;
                expire = (m_st == 2) && (m_win != 0) && (el == m_win - 1);
                fin    = (m_st == 2) && (stop || expire);
                exp_q.push_back({m_st == 1, m_st == 2, fin, m_done && m_irqen, m_ack});
                if (acc) begin
                    case (idx)
                        0:       rv = {28'd0, m_irqen, m_cont, 2'b00};
                        1:       rv = {29'd0, m_done, 2'(m_st)};
                        2:       rv = m_window;
                        3:       rv = el;
                        4:       rv = m_runs;
                        default: rv = 32'd0;
                    endcase
                    rd_q.push_back(rd ? rv : 32'd0);
                end
                if ((m_st == 0 || m_st == 3) && start) begin
                    m_st = 1; m_win = m_window; m_elapsed = 0; m_t0 = cur + 2;
                end else if (m_st == 1) begin
                    m_st = stop ? 3 : 2;
                end else if (fin) begin
                    m_runs = m_runs + 1;
                    m_elapsed = el;
                    if (!stop && m_cont) begin
                        m_st = 1; m_win = m_window; m_elapsed = 0; m_t0 = cur + 2;
                    end else begin
                        m_st = 3;
                    end
                end
                m_ack = acc;
                if (wr && idx == 0) begin
                    m_cont = d[2];
                    m_irqen = d[3];
                end
                if (wr && idx == 2) m_window = d;
                if (fin) m_done = 1'b1;
                else if (wr && idx == 1 && d[2]) m_done = 1'b0;
            end
        end
    endtask

    task automatic mon_proc();
        logic [4:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outputs{clr,en,snap,irq,ack}",
                      {27'd0, cnt_clr, cnt_en, snap, irq, wb_ack}, {27'd0, e});
            end
            if (wb_ack === 1'b1) begin
                if (rd_q.size() != 0) begin
                    check("rdata", wb_dat_i, rd_q.pop_front());
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ack_without_access: actual=ack expected=no ack at %0t", $time);
                end
            end
            if (cnt_en === 1'b1) en_total++;
            if (cnt_clr === 1'b1) clr_total++;
            if (snap === 1'b1) begin
                snap_en[snap_total % 8] = en_total;
                snap_total++;
            end
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] d,
                            output logic [31:0] rdat);
        int   lat;
        logic got;
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_o = d;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
            if (wb_ack === 1'b1) got = 1'b1;
        end
        rdat = wb_dat_i;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] d);
        logic [31:0] t;
        bus_xfer(1'b1, BASE + 32'(idx * 4), d, t);
    endtask

    task automatic rd_reg(input int idx, output logic [31:0] v);
        bus_xfer(1'b0, BASE + 32'(idx * 4), 32'd0, v);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int en0, clr0, sn0, b, r;
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 32'd0; wb_dat_o = 32'd0;
        fork
            model_proc();
            mon_proc();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_outputs", {26'd0, cnt_clr, cnt_en, snap, irq, wb_ack, wb_err | wb_rty}, 32'd0);
        rd_reg(1, v); check("reset_status", v, 32'd0);
        rd_reg(2, v); check("reset_window", v, RSTW);
        rd_reg(4, v); check("reset_runs", v, 32'd0);

        // Single window of 5
        wr_reg(2, 32'd5);
        en0 = en_total; clr0 = clr_total; sn0 = snap_total;
        wr_reg(0, 32'h1);
        repeat (10) @(posedge clk);
        check("w5_en_cycles", 32'(en_total - en0), 32'd5);
        check("w5_clr_pulses", 32'(clr_total - clr0), 32'd1);
        check("w5_snaps", 32'(snap_total - sn0), 32'd1);
        check("w5_snap_on_last_en", 32'(snap_en[sn0 % 8] - en0), 32'd5);
        rd_reg(1, v); check("w5_status", v, 32'h7);
        rd_reg(4, v); check("w5_runs", v, 32'd1);
        rd_reg(3, v); check("w5_elapsed", v, 32'd4);

        // Continuous windows of 3 with interrupt enabled
        do_reset();
        wr_reg(2, 32'd3);
        wr_reg(0, 32'hC);
        wr_reg(0, 32'hD);
        en0 = en_total; clr0 = clr_total; sn0 = snap_total;
        repeat (12) @(posedge clk);
        #2;
        check("cont_clr", 32'(clr_total - clr0), 32'd3);
        check("cont_en", 32'(en_total - en0), 32'd9);
        check("cont_snaps", 32'(snap_total - sn0), 32'd3);
        check("cont_irq", {31'd0, irq}, 32'd1);
        wr_reg(0, 32'h2);

        // Unbounded window ended by STOP
        do_reset();
        wr_reg(2, 32'd0);
        wr_reg(0, 32'h1);
        sn0 = snap_total;
        repeat (100) @(posedge clk);
        wr_reg(0, 32'h2);
        check("unb_snaps", 32'(snap_total - sn0), 32'd1);
        rd_reg(1, v); check("unb_state", {30'd0, v[1:0]}, 32'd3);
        rd_reg(4, v); check("unb_runs", v, 32'd1);
        rd_reg(3, v); check("unb_elapsed_near_100", {31'd0, (v >= 32'd95 && v <= 32'd110)}, 32'd1);

        // START|STOP from IDLE does nothing; W1C clears DONE and irq
        do_reset();
        en0 = en_total; clr0 = clr_total; sn0 = snap_total;
        wr_reg(0, 32'h3);
        repeat (3) @(posedge clk);
        check("ss_no_pulses", 32'((en_total - en0) + (clr_total - clr0) + (snap_total - sn0)), 32'd0);
        rd_reg(1, v); check("ss_status", v, 32'd0);
        wr_reg(2, 32'd2);
        wr_reg(0, 32'h9);
        repeat (6) @(posedge clk);
        #2;
        check("irq_set", {31'd0, irq}, 32'd1);
        wr_reg(1, 32'h4);
        rd_reg(1, v); check("w1c_status", v, 32'd3);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // WINDOW rewrite mid-run applies from the next window
        do_reset();
        wr_reg(2, 32'd10);
        wr_reg(0, 32'h5);
        en0 = en_total;
        b = snap_total;
        wr_reg(2, 32'd20);
        for (int i = 0; i < 200 && snap_total < b + 2; i++) @(posedge clk);
        check("rewin_snaps_seen", {31'd0, snap_total >= b + 2}, 32'd1);
        check("rewin_first_len", 32'(snap_en[b % 8] - en0), 32'd10);
        check("rewin_second_len", 32'(snap_en[(b + 1) % 8] - snap_en[b % 8]), 32'd20);
        wr_reg(0, 32'h2);

        // Reset during RUN, with a bus write in the same cycle
        do_reset();
        wr_reg(2, 32'd50);
        wr_reg(0, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE + 32'h8; wb_dat_o = 32'd7;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("rst_outputs", {26'd0, cnt_clr, cnt_en, snap, irq, wb_ack, 1'b0}, 32'd0);
        check("rst_rdata", wb_dat_i, 32'd0);
        rd_reg(1, v); check("rst_status", v, 32'd0);
        rd_reg(2, v); check("rst_window", v, RSTW);

        // Randomized traffic checked by the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                rd_reg($urandom_range(0, 7), v);
            end else if (r < 65) begin
                wr_reg(0, 32'($urandom_range(0, 15)));
            end else if (r < 78) begin
                wr_reg(2, 32'($urandom_range(0, 9)));
            end else if (r < 86) begin
                wr_reg(1, 32'($urandom_range(0, 7)));
            end else if (r < 90) begin
                wr_reg($urandom_range(3, 7), $urandom);
            end else if (r < 98) begin
                repeat ($urandom_range(1, 12)) @(posedge clk);
            end else begin
                do_reset();
            end
        end

        repeat (4) @(posedge clk);
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
